// File: rtl/clk_div_prog_if.sv
// Ratio-update handshake between a controller and clk_div_prog.
// The controller drives div_i/div_valid_i; the divider answers with div_ready_o.
interface clk_div_prog_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div_i;
    logic             div_valid_i;
    logic             div_ready_o;

    modport master (output div_i, output div_valid_i, input  div_ready_o);
    modport slave  (input  div_i, input  div_valid_i, output div_ready_o);
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a tick enable pulse.
// Ratio changes and start/stop take effect only on period boundaries.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             en_i,
    clk_div_prog_if.slave    div_if,
    input  logic             err_clr_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             err_o
);

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             div_legal;
    logic             period_end;
    logic [DIV_W-1:0] cnt_inc;

    // High-phase length ceil(n/2); odd ratios are high-biased.
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n);
        return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
    endfunction

    assign xfer       = div_if.div_valid_i & ~pend_vld_q;
    assign div_legal  = (div_if.div_i > DIV_W'(1));
    assign period_end = (cnt_q == (cur_div_q - DIV_W'(1)));
    assign cnt_inc    = cnt_q + DIV_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        clk_d      = 1'b0;
        tick_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (pend_vld_q) begin
                    cur_div_d  = pend_div_q;
                    pend_vld_d = 1'b0;
                end
                if (en_i) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (period_end) begin
                    // The pending ratio lands here even if this edge also stops the clock.
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        cur_div_d  = pend_div_q;
                        pend_vld_d = 1'b0;
                    end
                    if (en_i) begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len(cur_div_q));
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase

        // Transfers only happen with pending empty, so they never collide with an apply.
        if (xfer && div_legal) begin
            pend_vld_d = 1'b1;
            pend_div_d = div_if.div_i;
        end

        if (xfer && !div_legal)
            err_d = 1'b1;
        else if (err_clr_i)
            err_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_STOP;
            cnt_q      <= '0;
            cur_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    // Pending value is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        pend_div_q <= pend_div_d;
    end

    assign clk_o              = clk_q;
    assign tick_o             = tick_q;
    assign cur_div_o          = cur_div_q;
    assign err_o              = err_q;
    assign div_if.div_ready_o = ~pend_vld_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with a 4-bit divisor (max ratio 15).
module tb_clk_div_prog;

    localparam int DIV_W = 4;

    logic             clk_i;
    logic             reset_n;
    logic             en_i;
    logic             err_clr_i;
    logic             clk_o;
    logic             tick_o;
    logic [DIV_W-1:0] cur_div_o;
    logic             err_o;

    int n_vec;
    int n_err;

    clk_div_prog_if #(.DIV_W(DIV_W)) dif ();

    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .en_i      (en_i),
        .div_if    (dif),
        .err_clr_i (err_clr_i),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .cur_div_o (cur_div_o),
        .err_o     (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic program_div(input logic [DIV_W-1:0] d);
        dif.div_i       = d;
        dif.div_valid_i = 1'b1;
        step();
        dif.div_valid_i = 1'b0;
    endtask

    task automatic pulse_reset();
        en_i    = 1'b0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        reset_n         = 1'b0;
        en_i            = 1'b0;
        err_clr_i       = 1'b0;
        dif.div_i       = '0;
        dif.div_valid_i = 1'b0;

        // Reset state
        step();
        step();
        check_val("rst_clk",   clk_o, 0);
        check_val("rst_tick",  tick_o, 0);
        check_val("rst_cur",   cur_div_o, 2);
        check_val("rst_ready", dif.div_ready_o, 1);
        check_val("rst_err",   err_o, 0);
        reset_n = 1'b1;
        step();
        check_val("idle_clk", clk_o, 0);

        // Legacy divide-by-2
        en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("div2_clk",  clk_o, (i % 2 == 0));
            check_val("div2_tick", tick_o, (i % 2 == 0));
        end

        // Program 5 while running at 2; last edge left us at end of period
        dif.div_i       = 4'd5;
        dif.div_valid_i = 1'b1;
        step();
        dif.div_valid_i = 1'b0;
        check_val("p5_clk_a",   clk_o, 1);
        check_val("p5_ready_a", dif.div_ready_o, 0);
        check_val("p5_cur_a",   cur_div_o, 2);
        step();
        check_val("p5_clk_b",   clk_o, 0);
        check_val("p5_ready_b", dif.div_ready_o, 0);
        check_val("p5_cur_b",   cur_div_o, 2);
        step();
        check_val("p5_cur_c",   cur_div_o, 5);
        check_val("p5_ready_c", dif.div_ready_o, 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            check_val("div5_clk",  clk_o, ((i % 5) < 3));
            check_val("div5_tick", tick_o, ((i % 5) == 0));
        end

        // Illegal ratios set the sticky error
        program_div(4'd1);
        check_val("ill1_err",   err_o, 1);
        check_val("ill1_ready", dif.div_ready_o, 1);
        check_val("ill1_cur",   cur_div_o, 5);
        program_div(4'd0);
        check_val("ill0_err",   err_o, 1);
        check_val("ill0_ready", dif.div_ready_o, 1);
        check_val("ill0_cur",   cur_div_o, 5);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check_val("clr_err", err_o, 0);
        err_clr_i = 1'b1;
        program_div(4'd0);
        check_val("setwins_err", err_o, 1);
        step();
        err_clr_i = 1'b0;
        check_val("clr2_err", err_o, 0);

        // N=4 programmed while stopped, then stop mid high phase
        pulse_reset();
        program_div(4'd4);
        check_val("p4_ready_a", dif.div_ready_o, 0);
        step();
        check_val("p4_cur",     cur_div_o, 4);
        check_val("p4_ready_b", dif.div_ready_o, 1);
        check_val("p4_clk_idle", clk_o, 0);
        en_i = 1'b1;
        step();
        check_val("n4_start_clk",  clk_o, 1);
        check_val("n4_start_tick", tick_o, 1);
        en_i = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            check_val("n4_stop_clk",  clk_o, (i < 2));
            check_val("n4_stop_tick", tick_o, 0);
        end
        en_i = 1'b1;
        step();
        check_val("n4_restart_clk",  clk_o, 1);
        check_val("n4_restart_tick", tick_o, 1);

        // Reset mid high phase of N=6 with 9 pending
        pulse_reset();
        program_div(4'd6);
        step();
        check_val("p6_cur", cur_div_o, 6);
        en_i = 1'b1;
        step();
        check_val("n6_clk_a", clk_o, 1);
        program_div(4'd9);
        check_val("n6_clk_b",   clk_o, 1);
        check_val("n6_ready_b", dif.div_ready_o, 0);
        reset_n = 1'b0;
        en_i    = 1'b0;
        #1;
        check_val("arst_clk",   clk_o, 0);
        check_val("arst_tick",  tick_o, 0);
        check_val("arst_cur",   cur_div_o, 2);
        check_val("arst_ready", dif.div_ready_o, 1);
        #2;
        reset_n = 1'b1;
        step();
        step();
        check_val("arst_cur_after", cur_div_o, 2);
        check_val("arst_clk_after", clk_o, 0);

        // Maximum ratio 15 over three periods
        program_div(4'd15);
        step();
        check_val("p15_cur", cur_div_o, 15);
        en_i = 1'b1;
        begin
            int highs;
            highs = 0;
            for (int i = 0; i < 45; i++) begin
                step();
                check_val("n15_clk",  clk_o, ((i % 15) < 8));
                check_val("n15_tick", tick_o, ((i % 15) == 0));
                if (clk_o === 1'b1) highs++;
            end
            check_val("n15_highs", highs, 24);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
